// File: rtl/pacman_pkg.sv
// Shared maze-actor types: headings, tile classes, mover states and heading arithmetic.
package pacman_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    UP    = 2'd1,
    LEFT  = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PELLET = 2'd1,
    POWER  = 2'd2,
    WALL   = 2'd3
  } tile_t;

  typedef enum logic {
    MOVE    = 1'b0,
    BLOCKED = 1'b1
  } mstate_t;

  // Headings are numbered counter-clockwise, so a left turn is +1 mod 4.
  function automatic dir_t turn_left(input dir_t d);
    return dir_t'(d + 2'd1);
  endfunction

  function automatic dir_t turn_right(input dir_t d);
    return dir_t'(d - 2'd1);
  endfunction

  function automatic dir_t reverse(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/turn_buffer.sv
// Holds one pre-requested turn until it is taken, cancelled by a U-turn, or its tick budget runs out.
module turn_buffer
  import pacman_pkg::*;
#(
  parameter int TURN_HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  input  dir_t dir_i,
  input  logic left_i,
  input  logic right_i,
  input  logic uturn_i,
  input  logic tick_i,
  input  logic take_i,
  output dir_t pend_o,
  output logic vld_o
);

  localparam int HW = $clog2(TURN_HOLD + 1);

  dir_t          pend_q, pend_d;
  logic          vld_q, vld_d;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    pend_d = pend_q;
    vld_d  = vld_q;
    hold_d = hold_q;
    if (uturn_i) begin
      vld_d  = 1'b0;
      hold_d = '0;
    end else if (left_i ^ right_i) begin
      // A fresh request always replaces whatever was pending and restarts the budget.
      vld_d  = 1'b1;
      pend_d = left_i ? turn_left(dir_i) : turn_right(dir_i);
      hold_d = HW'(TURN_HOLD);
    end else if (vld_q && take_i) begin
      vld_d  = 1'b0;
      hold_d = '0;
    end else if (vld_q && tick_i) begin
      if (hold_q <= HW'(1)) begin
        vld_d  = 1'b0;
        hold_d = '0;
      end else begin
        hold_d = hold_q - HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= RIGHT;
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      vld_q  <= vld_d;
      hold_q <= hold_d;
    end
  end

  assign pend_o = pend_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/actor_motion.sv
// Tile-grid mover for one maze actor: fractional speed, buffered turns, tunnel wrap, wall blocking.
module actor_motion
  import pacman_pkg::*;
#(
  parameter int TILE_BITS = 3,
  parameter int X_TILES   = 28,
  parameter int Y_OFFSET  = 3,
  parameter int SPEED_W   = 8,
  parameter int TURN_HOLD = 16,
  parameter int START_X   = 108,
  parameter int START_Y   = 212,
  parameter int START_DIR = 2
) (
  input  logic               clk,
  input  logic               start,
  input  logic               tick,
  input  logic [SPEED_W-1:0] speed,
  input  logic               freeze,
  input  logic               left,
  input  logic               right,
  input  logic               uturn,
  input  logic [1:0]         tile_info [0:3],
  output logic [9:0]         x,
  output logic [9:0]         y,
  output logic [1:0]         dir,
  output logic [6:0]         xtile,
  output logic [6:0]         ytile,
  output logic               moving,
  output logic               at_center
);

  localparam logic [9:0]           X_MAX  = 10'(X_TILES * (2 ** TILE_BITS) - 1);
  localparam logic [TILE_BITS-1:0] CENTER = TILE_BITS'(2 ** (TILE_BITS - 1));

  mstate_t            state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  dir_t               dir_q, dir_d;
  logic [SPEED_W-1:0] acc_q, acc_d;
  logic [SPEED_W:0]   sum;

  dir_t pend;
  logic pend_vld;
  logic run, turn_ok, wall_hit, take;
  dir_t dir_eff;

  assign at_center = (x_q[TILE_BITS-1:0] == CENTER) && (y_q[TILE_BITS-1:0] == CENTER);
  assign xtile     = 7'(x_q >> TILE_BITS);
  assign ytile     = 7'((y_q >> TILE_BITS) - 10'(Y_OFFSET));
  assign x         = x_q;
  assign y         = y_q;
  assign dir       = dir_q;
  assign moving    = (state_q == MOVE);

  // A U-turn pre-empts any movement in the same cycle.
  assign run  = tick && !freeze && !uturn;
  assign take = run && turn_ok;

  turn_buffer #(
    .TURN_HOLD(TURN_HOLD)
  ) u_turn_buffer (
    .clk    (clk),
    .rst    (start),
    .dir_i  (dir_q),
    .left_i (left),
    .right_i(right),
    .uturn_i(uturn),
    .tick_i (tick),
    .take_i (take),
    .pend_o (pend),
    .vld_o  (pend_vld)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    acc_d    = acc_q;
    turn_ok  = pend_vld && at_center && (tile_info[pend] != WALL);
    dir_eff  = turn_ok ? pend : dir_q;
    wall_hit = at_center && (tile_info[dir_eff] == WALL);
    sum      = {1'b0, acc_q} + {1'b0, speed};

    if (uturn && !freeze) begin
      dir_d   = reverse(dir_q);
      state_d = MOVE;
    end else if (run) begin
      dir_d = dir_eff;
      if (wall_hit) begin
        state_d = BLOCKED;
        acc_d   = '0;
      end else begin
        state_d = MOVE;
        acc_d   = sum[SPEED_W-1:0];
        // The accumulator carry is the only source of motion, capping speed at 1 px per tick.
        if (sum[SPEED_W]) begin
          case (dir_eff)
            RIGHT:   x_d = (x_q == X_MAX) ? 10'd0 : x_q + 10'd1;
            LEFT:    x_d = (x_q == 10'd0) ? X_MAX : x_q - 10'd1;
            UP:      y_d = y_q - 10'd1;
            DOWN:    y_d = y_q + 10'd1;
            default: x_d = x_q;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      state_q <= MOVE;
      x_q     <= 10'(START_X);
      y_q     <= 10'(START_Y);
      dir_q   <= dir_t'(2'(START_DIR));
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_actor_motion.sv
// Directed bench for actor_motion: per-cycle comparison against a behavioural model plus literal pins.
module tb_actor_motion;

  localparam int TURN_HOLD = 16;
  localparam int WIDTH_PX  = 224;

  logic       clk = 1'b0;
  logic       start, tick, freeze, left, right, uturn;
  logic [7:0] speed;
  logic [1:0] tile_info [0:3];
  logic [9:0] x, y;
  logic [1:0] dir;
  logic [6:0] xtile, ytile;
  logic       moving, at_center;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  int mx, my, mdir, macc, mpend, mttl, m_d, m_od;
  bit mblk, m_centre;

  actor_motion dut (
    .clk      (clk),
    .start    (start),
    .tick     (tick),
    .speed    (speed),
    .freeze   (freeze),
    .left     (left),
    .right    (right),
    .uturn    (uturn),
    .tile_info(tile_info),
    .x        (x),
    .y        (y),
    .dir      (dir),
    .xtile    (xtile),
    .ytile    (ytile),
    .moving   (moving),
    .at_center(at_center)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge start) begin
    if (start) begin
      mx = 108; my = 212; mdir = 2; macc = 0; mpend = 0; mttl = 0; mblk = 1'b0;
    end else begin
      m_od = mdir;
      if (uturn) begin
        mttl = 0;
        if (!freeze) begin
          mdir = (mdir + 2) % 4;
          mblk = 1'b0;
        end
      end else begin
        if (tick) begin
          if (freeze) begin
            if (mttl > 0) mttl--;
          end else begin
            m_centre = (mx % 8 == 4) && (my % 8 == 4);
            m_d = mdir;
            if (mttl > 0 && m_centre && tile_info[mpend] != 2'd3) begin
              m_d = mpend;
              mttl = 0;
            end else if (mttl > 0) begin
              mttl--;
            end
            mdir = m_d;
            if (m_centre && tile_info[m_d] == 2'd3) begin
              mblk = 1'b1;
              macc = 0;
            end else begin
              mblk = 1'b0;
              macc = macc + speed;
              if (macc >= 256) begin
                macc = macc - 256;
                case (m_d)
                  0: mx = (mx + 1) % WIDTH_PX;
                  2: mx = (mx + WIDTH_PX - 1) % WIDTH_PX;
                  1: my = my - 1;
                  default: my = my + 1;
                endcase
              end
            end
          end
        end
        if (left ^ right) begin
          mpend = left ? (m_od + 1) % 4 : (m_od + 3) % 4;
          mttl  = TURN_HOLD;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !start) begin
      check("x", x, mx);
      check("y", y, my);
      check("dir", dir, mdir);
      check("xtile", xtile, mx / 8);
      check("ytile", ytile, my / 8 - 3);
      check("moving", moving, mblk ? 0 : 1);
      check("at_center", at_center, ((mx % 8 == 4) && (my % 8 == 4)) ? 1 : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  task automatic pulse(input logic l, input logic r, input logic u);
    left = l; right = r; uturn = u;
    cyc();
    left = 1'b0; right = 1'b0; uturn = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    start = 1'b1; tick = 1'b0; freeze = 1'b0; left = 1'b0; right = 1'b0; uturn = 1'b0;
    speed = 8'd0;
    for (int i = 0; i < 4; i++) tile_info[i] = 2'd0;
    repeat (3) cyc();
    start = 1'b0;
    cyc();
    check("rst_x", x, 108);
    check("rst_y", y, 212);
    check("rst_dir", dir, 2);
    check("rst_xtile", xtile, 13);
    check("rst_ytile", ytile, 23);
    check("rst_moving", moving, 1);
    check("rst_at_center", at_center, 1);
    chk_en = 1'b1;

    // half speed and full speed, including the left tunnel wrap
    speed = 8'd128;
    do_tick(8);
    check("half_speed_x", x, 104);
    speed = 8'd255;
    do_tick(256);
    check("full_speed_wrap_x", x, 73);

    // buffered right turn taken at the next centre
    do_tick(3);
    check("preturn_x", x, 71);
    pulse(1'b0, 1'b1, 1'b0);
    do_tick(3);
    check("at_centre_x", x, 68);
    check("not_yet_turned", dir, 2);
    do_tick(1);
    check("turned_dir", dir, 1);
    check("turned_y", y, 211);

    // left turn back to heading left, then a wall-blocked right turn that expires
    pulse(1'b1, 1'b0, 1'b0);
    do_tick(8);
    check("left_turn_dir", dir, 2);
    check("left_turn_x", x, 67);
    do_tick(4);
    tile_info[1] = 2'd3;
    pulse(1'b0, 1'b1, 1'b0);
    do_tick(16);
    tile_info[1] = 2'd0;
    do_tick(4);
    check("expired_dir", dir, 2);
    check("expired_x", x, 43);

    // wall ahead: block, hold, then U-turn out
    tile_info[2] = 2'd3;
    do_tick(8);
    check("blocked_moving", moving, 0);
    check("blocked_x", x, 36);
    do_tick(10);
    check("blocked_hold_x", x, 36);
    pulse(1'b0, 1'b0, 1'b1);
    check("uturn_dir", dir, 0);
    check("uturn_moving", moving, 1);
    tile_info[2] = 2'd0;
    do_tick(2);
    check("uturn_step_x", x, 37);

    // right tunnel wrap and back again
    do_tick(186);
    check("edge_x", x, 223);
    do_tick(1);
    check("wrap_right_x", x, 0);
    pulse(1'b0, 1'b0, 1'b1);
    do_tick(1);
    check("wrap_left_x", x, 223);
    check("wrap_left_dir", dir, 2);

    // simultaneous requests: both ignored; U-turn beats left
    pulse(1'b1, 1'b1, 1'b0);
    do_tick(4);
    check("lr_ignored_dir", dir, 2);
    check("lr_ignored_x", x, 219);
    pulse(1'b1, 1'b0, 1'b1);
    do_tick(2);
    check("uturn_wins_dir", dir, 0);
    check("uturn_wins_x", x, 221);

    // asynchronous reset mid-cycle
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    #2;
    start = 1'b1;
    #1;
    check("async_x", x, 108);
    check("async_y", y, 212);
    check("async_dir", dir, 2);
    check("async_moving", moving, 1);
    cyc();
    start = 1'b0;
    cyc();

    // freeze holds position and accumulator
    freeze = 1'b1;
    do_tick(3);
    check("freeze_x", x, 108);
    freeze = 1'b0;
    do_tick(2);
    check("unfreeze_x", x, 107);

    chk_en = 1'b0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
